// File: rtl/btn_conditioner.sv
// Push-button conditioner: synchronizes, debounces and arbitrates up/down/clr
// buttons into registered levels and single-cycle press ticks.
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic up_in,
  input  logic down_in,
  input  logic clr_in,
  output logic up,
  output logic down,
  output logic clr,
  output logic up_tick,
  output logic down_tick,
  output logic clr_tick
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

  localparam logic [19:0] CNT_MAX = 20'(DB_CYCLES - 1);

  // Channel index: 0 = up, 1 = down, 2 = clr
  logic [2:0] raw;
  logic [2:0] sync_p0;
  logic [2:0] sync_p1;
  logic [2:0] lvl;
  logic [2:0] rise_p2;

  assign raw = {clr_in, down_in, up_in};

  // Stage p0/p1: two-flop synchronizer, sync_p1 is the sampled level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-channel debounce FSM, rise strobe registered on WAIT1->ONE
  for (genvar i = 0; i < 3; i++) begin : g_ch
    db_state_t   state;
    db_state_t   state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        rise_nxt;
    logic        rise_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state  <= ZERO;
        cnt    <= '0;
        rise_q <= 1'b0;
      end else begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        rise_q <= rise_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      unique case (state)
        ZERO: begin
          if (sync_p1[i]) begin
            state_nxt = WAIT1;
            cnt_nxt   = '0;
          end
        end
        WAIT1: begin
          if (!sync_p1[i]) begin
            state_nxt = ZERO;
          end else if (cnt == CNT_MAX) begin
            state_nxt = ONE;
            rise_nxt  = 1'b1;
          end else begin
            cnt_nxt = cnt + 20'd1;
          end
        end
        ONE: begin
          if (!sync_p1[i]) begin
            state_nxt = WAIT0;
            cnt_nxt   = '0;
          end
        end
        WAIT0: begin
          // A return to 1 before the gap qualifies is a bounce, not a new press
          if (sync_p1[i]) begin
            state_nxt = ONE;
          end else if (cnt == CNT_MAX) begin
            state_nxt = ZERO;
          end else begin
            cnt_nxt = cnt + 20'd1;
          end
        end
        default: state_nxt = ZERO;
      endcase
    end

    assign lvl[i]     = (state == ONE) || (state == WAIT0);
    assign rise_p2[i] = rise_q;
  end

  // Stage p3: registered arbitration; clr dominates, up+down together holds
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      up        <= 1'b0;
      down      <= 1'b0;
      clr       <= 1'b0;
      up_tick   <= 1'b0;
      down_tick <= 1'b0;
      clr_tick  <= 1'b0;
    end else begin
      clr       <= lvl[2];
      up        <= lvl[0] & ~lvl[1] & ~lvl[2];
      down      <= lvl[1] & ~lvl[0] & ~lvl[2];
      up_tick   <= rise_p2[0];
      down_tick <= rise_p2[1];
      clr_tick  <= rise_p2[2];
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4 (press visible after 8 edges).
module tb_btn_conditioner;

  logic clk;
  logic reset;
  logic up_in, down_in, clr_in;
  logic up, down, clr, up_tick, down_tick, clr_tick;
  logic [5:0] obs;

  int total;
  int passed;

  btn_conditioner #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .up_in    (up_in),
    .down_in  (down_in),
    .clr_in   (clr_in),
    .up       (up),
    .down     (down),
    .clr      (clr),
    .up_tick  (up_tick),
    .down_tick(down_tick),
    .clr_tick (clr_tick)
  );

  // {up, down, clr, up_tick, down_tick, clr_tick}
  assign obs = {up, down, clr, up_tick, down_tick, clr_tick};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b required %b", tag, obs, exp);
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    reset   = 1'b0;
    up_in   = 1'b0;
    down_in = 1'b0;
    clr_in  = 1'b0;

    step(3);
    chk("reset_hold", 6'b000000);
    reset = 1'b1;
    step(2);
    chk("idle_after_reset", 6'b000000);

    // Single clean press and release of up
    up_in = 1'b1;
    step(7);
    chk("up_press_edge7", 6'b000000);
    step(1);
    chk("up_press_edge8", 6'b100100);
    step(1);
    chk("up_tick_one_cycle", 6'b100000);
    step(5);
    chk("up_held", 6'b100000);
    up_in = 1'b0;
    step(7);
    chk("up_release_edge7", 6'b100000);
    step(1);
    chk("up_release_edge8", 6'b000000);
    step(3);
    chk("no_tick_on_release", 6'b000000);

    // Short 3-cycle glitch must be rejected
    up_in = 1'b1;
    step(3);
    up_in = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("short_pulse", 6'b000000);
    end

    // Press, then 2-cycle bounce while held
    up_in = 1'b1;
    step(8);
    chk("bounce_press", 6'b100100);
    step(1);
    chk("bounce_pretick", 6'b100000);
    up_in = 1'b0;
    step(2);
    up_in = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step(1);
      chk("bounce_hold", 6'b100000);
    end

    // up and down pressed together, then down released
    up_in = 1'b0;
    step(10);
    chk("idle_before_both", 6'b000000);
    up_in   = 1'b1;
    down_in = 1'b1;
    step(7);
    chk("both_edge7", 6'b000000);
    step(1);
    chk("both_ticks", 6'b000110);
    step(1);
    chk("both_hold", 6'b000000);
    down_in = 1'b0;
    step(7);
    chk("down_release_edge7", 6'b000000);
    step(1);
    chk("down_release_up", 6'b100000);

    // clr overrides a held up
    clr_in = 1'b1;
    step(7);
    chk("clr_press_edge7", 6'b100000);
    step(1);
    chk("clr_press_edge8", 6'b001001);
    step(1);
    chk("clr_hold", 6'b001000);
    step(5);
    chk("clr_hold_long", 6'b001000);
    clr_in = 1'b0;
    step(7);
    chk("clr_release_edge7", 6'b001000);
    step(1);
    chk("clr_release_up", 6'b100000);
    step(3);
    chk("clr_release_no_uptick", 6'b100000);

    // Asynchronous reset while up is asserted, button held through release
    #3;
    reset = 1'b0;
    #1;
    chk("async_reset_clears", 6'b000000);
    step(2);
    chk("reset_low_hold", 6'b000000);
    reset = 1'b1;
    step(7);
    chk("held_across_reset_edge7", 6'b000000);
    step(1);
    chk("held_across_reset_edge8", 6'b100100);
    step(1);
    chk("held_across_reset_after", 6'b100000);

    // Reset in the middle of a debounce discards the partial count
    up_in = 1'b0;
    step(10);
    chk("idle_before_mid_reset", 6'b000000);
    up_in = 1'b1;
    step(5);
    chk("mid_debounce", 6'b000000);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_reset_async", 6'b000000);
    step(2);
    chk("mid_reset_hold", 6'b000000);
    reset = 1'b1;
    step(7);
    chk("mid_reset_edge7", 6'b000000);
    step(1);
    chk("mid_reset_edge8", 6'b100100);
    step(1);
    chk("mid_reset_after", 6'b100000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
